// File: rtl/median_frame_sequencer_pkg.sv
// median_frame_sequencer_pkg: result-memory opcodes and sequencer FSM states
package median_frame_sequencer_pkg;
  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAITF,
    S_WRITE,
    S_NEXT,
    S_DONE,
    S_ABORT
  } state_t;
endpackage

// File: rtl/median_frame_sequencer_scan.sv
// window_scan_counter: raster row/col counter over interior centres [R..W-1-R] x [R..H-1-R]
// Ports: clk, rst; clear reloads (R,R); step advances column-fastest; row/col current centre;
// last flags the final centre.
module window_scan_counter #(
  parameter int R  = 1,
  parameter int W  = 7,
  parameter int H  = 7,
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  output logic [BW-1:0] row,
  output logic [BW-1:0] col,
  output logic          last
);
  localparam logic [BW-1:0] LO   = BW'(R);
  localparam logic [BW-1:0] CMAX = BW'(W - 1 - R);
  localparam logic [BW-1:0] RMAX = BW'(H - 1 - R);
  assign last = (row == RMAX) && (col == CMAX);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= LO;
      col <= LO;
    end else if (step) begin
      col <= (col == CMAX) ? LO : col + 1'b1;
      row <= (col == CMAX) ? row + 1'b1 : row;
    end
  end
endmodule

// File: rtl/median_frame_sequencer.sv
// median_frame_sequencer: walks interior window centres, feeds Median_Filter, stores results
// Ports: clk, rst (sync, active-high); start/busy/done/err/win_count frame control;
// filt_en/sROW/sCOL/filter_out/filt_rdy filter handshake;
// res_rw/res_addr/res_idata/res_drdy result-memory write port.
module median_frame_sequencer
  import median_frame_sequencer_pkg::*;
#(
  parameter int WINDOW_SIZE = 3,
  parameter int DATA_WIDTH  = 16,
  parameter int BUS_WIDTH   = 8,
  parameter int IMG_WIDTH   = 7,
  parameter int IMG_HEIGHT  = 7,
  parameter int OUT_BASE    = 0,
  parameter int TIMEOUT     = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [BUS_WIDTH-1:0]  win_count,
  output logic                  filt_en,
  output logic [BUS_WIDTH-1:0]  sROW,
  output logic [BUS_WIDTH-1:0]  sCOL,
  input  logic [DATA_WIDTH-1:0] filter_out,
  input  logic                  filt_rdy,
  output logic [1:0]            res_rw,
  output logic [BUS_WIDTH-1:0]  res_addr,
  output logic [DATA_WIDTH-1:0] res_idata,
  input  logic                  res_drdy
);
  localparam int R     = WINDOW_SIZE / 2;
  localparam int OUT_W = IMG_WIDTH - 2 * R;
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam bit DEGEN = (IMG_WIDTH < WINDOW_SIZE) || (IMG_HEIGHT < WINDOW_SIZE);
  state_t state, next;
  logic [TW-1:0] tcnt;
  logic [BUS_WIDTH-1:0] row, col, addr;
  logic last, go, tout;
  assign go   = (state == S_IDLE) && start;
  assign tout = tcnt == TW'(TIMEOUT - 1);
  window_scan_counter #(
    .R (R),
    .W (IMG_WIDTH),
    .H (IMG_HEIGHT),
    .BW(BUS_WIDTH)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .clear(go),
    .step ((state == S_NEXT) && !last),
    .row  (row),
    .col  (col),
    .last (last)
  );
  always_comb begin
    next = state;
    case (state)
      S_IDLE:  next = start ? (DEGEN ? S_DONE : S_ISSUE) : S_IDLE;
      S_ISSUE: next = S_WAITF;
      S_WAITF: next = filt_rdy ? S_WRITE : (tout ? S_ABORT : S_WAITF);
      S_WRITE: next = res_drdy ? S_NEXT : (tout ? S_ABORT : S_WRITE);
      S_NEXT:  next = last ? S_DONE : S_ISSUE;
      default: next = S_IDLE;
    endcase
  end
  always_comb begin
    addr     = BUS_WIDTH'(OUT_BASE) + (row - BUS_WIDTH'(R)) * BUS_WIDTH'(OUT_W) + (col - BUS_WIDTH'(R));
    busy     = (state == S_ISSUE) || (state == S_WAITF) || (state == S_WRITE) || (state == S_NEXT);
    done     = state == S_DONE;
    filt_en  = (state == S_ISSUE) || (state == S_WAITF);
    res_rw   = (state == S_WRITE) ? RW_WRITE : RW_IDLE;
    sROW     = busy ? row : '0;
    sCOL     = busy ? col : '0;
    res_addr = busy ? addr : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      win_count <= '0;
      res_idata <= '0;
      err       <= 1'b0;
    end else begin
      state <= next;
      tcnt  <= (next != state) ? '0 : tcnt + 1'b1;
      if (go) win_count <= '0;
      else if ((state == S_WRITE) && res_drdy) win_count <= win_count + 1'b1;
      if ((state == S_WAITF) && filt_rdy) res_idata <= filter_out;
      if (go) err <= 1'b0;
      else if (next == S_ABORT) err <= 1'b1;
    end
  end
endmodule
